// File: rtl/ldtu_ofifo_param.sv
// Parametrised output FIFO between the Hamming encoder and the readout path.
// Registered read data with an aligned valid pulse, level/watermarks and sticky error flags.
module ldtu_ofifo_param #(
  parameter int unsigned      NBITS     = 38,
  parameter int unsigned      PTR_BITS  = 4,
  parameter int unsigned      AFULL_TH  = 12,
  parameter int unsigned      AEMPTY_TH = 2,
  parameter logic [NBITS-1:0] IDLE_WORD = {NBITS{1'b0}} | 32'h4000_0000
) (
  input  logic                CLK,
  input  logic                rst_b,
  input  logic                start_write,
  input  logic [NBITS-1:0]    data_input,
  input  logic                read_signal,
  input  logic                clr_flags,
  output logic [NBITS-1:0]    data_output,
  output logic                decode_signal,
  output logic                empty_signal,
  output logic                full_signal,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [PTR_BITS:0]   level,
  output logic                overflow,
  output logic                underflow,
  output logic                SeuError
);

  localparam int unsigned DEPTH = 2 ** PTR_BITS;

  localparam logic [PTR_BITS:0] AfullLvl  = AFULL_TH[PTR_BITS:0];
  localparam logic [PTR_BITS:0] AemptyLvl = AEMPTY_TH[PTR_BITS:0];

  logic [PTR_BITS:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS:0] rd_ptr_q, rd_ptr_d;
  logic [NBITS-1:0]  dout_q, dout_d;
  logic              dec_q, dec_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic [NBITS-1:0]  mem_q [DEPTH];

  logic              empty, full;
  logic              wr_acc, rd_acc;
  logic [PTR_BITS:0] lvl;

  // Status depends only on the registered pointers, never on this cycle's requests.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[PTR_BITS] != rd_ptr_q[PTR_BITS]) &&
            (wr_ptr_q[PTR_BITS-1:0] == rd_ptr_q[PTR_BITS-1:0]);
    lvl   = wr_ptr_q - rd_ptr_q;
  end

  assign wr_acc = start_write & ~full;
  assign rd_acc = read_signal & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    dout_d   = dout_q;
    dec_d    = 1'b0;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      dout_d   = mem_q[rd_ptr_q[PTR_BITS-1:0]];
      dec_d    = 1'b1;
    end
    // A new error in the same cycle as a clear keeps the flag set.
    ovf_d = (ovf_q & ~clr_flags) | (start_write & full);
    udf_d = (udf_q & ~clr_flags) | (read_signal & empty);
  end

  always_ff @(posedge CLK or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= IDLE_WORD;
      dec_q    <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      dout_q   <= dout_d;
      dec_q    <= dec_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array carries no reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge CLK) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q[PTR_BITS-1:0]] <= data_input;
    end
  end

  assign data_output   = dout_q;
  assign decode_signal = dec_q;
  assign empty_signal  = empty;
  assign full_signal   = full;
  assign level         = lvl;
  assign almost_full   = (lvl >= AfullLvl);
  assign almost_empty  = (lvl <= AemptyLvl);
  assign overflow      = ovf_q;
  assign underflow     = udf_q;
  assign SeuError      = 1'b0;

endmodule

// File: tb/tb_ldtu_ofifo_param.sv
// Scoreboard bench for ldtu_ofifo_param: expected read words are queued as reads are issued
// and popped when the registered output is due.
`timescale 1ns/1ps
module tb_ldtu_ofifo_param;

  localparam logic [37:0] Idle = 38'h00_4000_0000;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        start_write;
  logic [37:0] data_input;
  logic        read_signal;
  logic        clr_flags;
  logic [37:0] data_output;
  logic        decode_signal;
  logic        empty_signal;
  logic        full_signal;
  logic        almost_full;
  logic        almost_empty;
  logic [4:0]  level;
  logic        overflow;
  logic        underflow;
  logic        seu_error;

  ldtu_ofifo_param dut (
    .CLK          (clk),
    .rst_b        (rst_b),
    .start_write  (start_write),
    .data_input   (data_input),
    .read_signal  (read_signal),
    .clr_flags    (clr_flags),
    .data_output  (data_output),
    .decode_signal(decode_signal),
    .empty_signal (empty_signal),
    .full_signal  (full_signal),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow),
    .SeuError     (seu_error)
  );

  always #5 clk = ~clk;

  logic [37:0] m_q[$];    // model of stored words
  logic [37:0] exp_q[$];  // scoreboard of words due on data_output
  logic [37:0] out_m;     // model of held output word
  logic [37:0] e;
  bit          dec_m, ovf_m, udf_m;
  int          n_cmp = 0;
  int          n_err = 0;

  // Drive one cycle of requests from a negedge; returns at the following negedge.
  task automatic drive(input logic wr, input logic [37:0] d, input logic rd, input logic clr);
    bit full_m, empty_m;
    start_write = wr; data_input = d; read_signal = rd; clr_flags = clr;
    full_m  = (m_q.size() == 16);
    empty_m = (m_q.size() == 0);
    dec_m   = rd && !empty_m;
    if (dec_m) exp_q.push_back(m_q.pop_front());
    if (wr && !full_m) m_q.push_back(d);
    ovf_m = (ovf_m && !clr) || (wr && full_m);
    udf_m = (udf_m && !clr) || (rd && empty_m);
    @(negedge clk);
    start_write = 1'b0; read_signal = 1'b0; clr_flags = 1'b0;
  endtask

  task automatic test_reset();
    rst_b = 1'b0; start_write = 1'b0; data_input = '0; read_signal = 1'b0; clr_flags = 1'b0;
    m_q.delete(); exp_q.delete(); out_m = Idle; ovf_m = 0; udf_m = 0; dec_m = 0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    n_cmp++; if (data_output !== Idle) begin n_err++;
      $display("FAIL reset_data: got %h want %h", data_output, Idle); end
    n_cmp++; if (empty_signal !== 1'b1 || almost_empty !== 1'b1) begin n_err++;
      $display("FAIL reset_empty: got %b/%b want 1/1", empty_signal, almost_empty); end
    n_cmp++; if (full_signal !== 1'b0 || almost_full !== 1'b0) begin n_err++;
      $display("FAIL reset_full: got %b/%b want 0/0", full_signal, almost_full); end
    n_cmp++; if (level !== 5'd0 || decode_signal !== 1'b0) begin n_err++;
      $display("FAIL reset_level_dec: got %0d/%b want 0/0", level, decode_signal); end
    n_cmp++; if (overflow !== 1'b0 || underflow !== 1'b0 || seu_error !== 1'b0) begin n_err++;
      $display("FAIL reset_flags: got %b%b%b want 000", overflow, underflow, seu_error); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      n_cmp++; if (decode_signal !== 1'b0 || data_output !== Idle) begin n_err++;
        $display("FAIL empty_read_hold: got %b/%h want 0/%h", decode_signal, data_output, Idle); end
      n_cmp++; if (underflow !== udf_m) begin n_err++;
        $display("FAIL empty_read_udf: got %b want %b", underflow, udf_m); end
    end
  endtask

  task automatic test_fill();
    drive(1'b0, '0, 1'b0, 1'b1);
    n_cmp++; if (underflow !== 1'b0) begin n_err++;
      $display("FAIL clr_udf: got %b want 0", underflow); end
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 38'(i), 1'b0, 1'b0);
      n_cmp++; if (level !== 5'(i)) begin n_err++;
        $display("FAIL fill_level: got %0d want %0d", level, i); end
      n_cmp++; if (almost_full !== (i >= 12) || full_signal !== (i == 16)) begin n_err++;
        $display("FAIL fill_af_full: got %b/%b want %b/%b", almost_full, full_signal,
                 i >= 12, i == 16); end
      n_cmp++; if (empty_signal !== 1'b0 || overflow !== 1'b0) begin n_err++;
        $display("FAIL fill_empty_ovf: got %b/%b want 0/0", empty_signal, overflow); end
    end
    drive(1'b1, 38'h11, 1'b0, 1'b0);
    n_cmp++; if (overflow !== 1'b1 || level !== 5'd16) begin n_err++;
      $display("FAIL fill_overflow: got %b/%0d want 1/16", overflow, level); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      n_cmp++; if (decode_signal !== dec_m) begin n_err++;
        $display("FAIL drain_decode: got %b want %b", decode_signal, dec_m); end
      if (dec_m) begin
        e = exp_q.pop_front(); out_m = e;
        n_cmp++; if (data_output !== e) begin n_err++;
          $display("FAIL drain_data: got %h want %h", data_output, e); end
      end
      n_cmp++; if (level !== 5'(m_q.size()) || almost_empty !== (m_q.size() <= 2)) begin n_err++;
        $display("FAIL drain_level: got %0d/%b want %0d/%b", level, almost_empty, m_q.size(),
                 m_q.size() <= 2); end
    end
    n_cmp++; if (empty_signal !== 1'b1 || underflow !== 1'b0) begin n_err++;
      $display("FAIL drain_empty: got %b/%b want 1/0", empty_signal, underflow); end
  endtask

  task automatic test_stream();
    drive(1'b0, '0, 1'b0, 1'b1);
    n_cmp++; if (overflow !== 1'b0) begin n_err++;
      $display("FAIL clr_ovf: got %b want 0", overflow); end
    for (int i = 0; i < 5; i++) drive(1'b1, 38'h100 + 38'(i), 1'b0, 1'b0);
    for (int i = 5; i < 45; i++) begin
      drive(1'b1, 38'h100 + 38'(i), 1'b1, 1'b0);
      n_cmp++; if (decode_signal !== 1'b1) begin n_err++;
        $display("FAIL stream_decode: got %b want 1", decode_signal); end
      e = exp_q.pop_front(); out_m = e;
      n_cmp++; if (data_output !== e) begin n_err++;
        $display("FAIL stream_data: got %h want %h", data_output, e); end
      n_cmp++; if (level !== 5'd5 || overflow !== 1'b0 || underflow !== 1'b0) begin n_err++;
        $display("FAIL stream_level_flags: got %0d/%b/%b want 5/0/0", level, overflow,
                 underflow); end
    end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 11; i++) drive(1'b1, 38'h200 + 38'(i), 1'b0, 1'b0);
    n_cmp++; if (full_signal !== 1'b1) begin n_err++;
      $display("FAIL rw_prefull: got %b want 1", full_signal); end
    drive(1'b1, 38'h3FF, 1'b1, 1'b0);
    e = exp_q.pop_front(); out_m = e;
    n_cmp++; if (decode_signal !== 1'b1 || data_output !== e) begin n_err++;
      $display("FAIL rw_full_read: got %b/%h want 1/%h", decode_signal, data_output, e); end
    n_cmp++; if (overflow !== 1'b1 || level !== 5'd15) begin n_err++;
      $display("FAIL rw_full_ovf: got %b/%0d want 1/15", overflow, level); end
    drive(1'b1, 38'h2FF, 1'b0, 1'b0);
    drive(1'b1, 38'h3FE, 1'b0, 1'b1);
    n_cmp++; if (overflow !== 1'b1 || level !== 5'd16) begin n_err++;
      $display("FAIL rw_set_wins: got %b/%0d want 1/16", overflow, level); end
    drive(1'b0, '0, 1'b0, 1'b1);
    n_cmp++; if (overflow !== 1'b0) begin n_err++;
      $display("FAIL rw_clr: got %b want 0", overflow); end
    // Rejected words must never show up in the drained stream.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      e = exp_q.pop_front(); out_m = e;
      n_cmp++; if (decode_signal !== 1'b1 || data_output !== e) begin n_err++;
        $display("FAIL rw_drain: got %b/%h want 1/%h", decode_signal, data_output, e); end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) drive(1'b1, 38'h500 + 38'(i), 1'b0, 1'b0);
    n_cmp++; if (level !== 5'd7) begin n_err++;
      $display("FAIL ar_level: got %0d want 7", level); end
    start_write = 1'b1; data_input = 38'h507; read_signal = 1'b1;
    @(posedge clk); #2;
    n_cmp++; if (decode_signal !== 1'b1 || data_output !== 38'h500) begin n_err++;
      $display("FAIL ar_preread: got %b/%h want 1/500", decode_signal, data_output); end
    rst_b = 1'b0;
    #1;
    n_cmp++; if (data_output !== Idle || decode_signal !== 1'b0) begin n_err++;
      $display("FAIL ar_out: got %h/%b want %h/0", data_output, decode_signal, Idle); end
    n_cmp++; if (level !== 5'd0 || empty_signal !== 1'b1 || almost_empty !== 1'b1) begin n_err++;
      $display("FAIL ar_status: got %0d/%b/%b want 0/1/1", level, empty_signal, almost_empty); end
    @(negedge clk);
    start_write = 1'b0; read_signal = 1'b0; rst_b = 1'b1;
    m_q.delete(); exp_q.delete(); out_m = Idle; ovf_m = 0; udf_m = 0; dec_m = 0;
    drive(1'b1, 38'hAA, 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    e = exp_q.pop_front();
    n_cmp++; if (decode_signal !== 1'b1 || data_output !== e || e !== 38'hAA) begin n_err++;
      $display("FAIL ar_after: got %b/%h want 1/0aa", decode_signal, data_output); end
    n_cmp++; if (level !== 5'd0 || overflow !== 1'b0 || underflow !== 1'b0) begin n_err++;
      $display("FAIL ar_after_status: got %0d/%b/%b want 0/0/0", level, overflow, underflow); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_fill();
    test_back_to_back();
    test_stream();
    test_full_rw();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
